// File: rtl/fx_gate_gen_if.sv
// Count-publish handshake between the clk_fx gate generator
// and the reference-clock consumer.
interface fx_gate_gen_if #(
  parameter int CNT_W = 32
);
  logic [CNT_W-1:0] fx_cnt;
  logic [7:0]       seq;
  logic             cnt_req;
  logic             cnt_ack;

  modport master (
    output fx_cnt,
    output seq,
    output cnt_req,
    input  cnt_ack
  );

  modport slave (
    input  fx_cnt,
    input  seq,
    input  cnt_req,
    output cnt_ack
  );
endinterface

// File: rtl/fx_gate_gen.sv
// Guarded gate window generator counting clk_fx cycles,
// publishing each count over a 4-phase handshake.
module fx_gate_gen #(
  parameter int CNT_W      = 32,
  parameter int PRE_GUARD  = 10,
  parameter int POST_GUARD = 10
) (
  input  logic          clk_fx,
  input  logic          rst_n,
  input  logic          en,
  input  logic [15:0]   gate_len,
  output logic          gate,
  output logic          busy,
  fx_gate_gen_if.master hs
);

  typedef enum logic [2:0] {
    IDLE,
    PRE,
    GATE,
    POST,
    HS_WAIT,
    HS_REL
  } state_t;

  localparam logic [15:0] PRE_LAST  = 16'(PRE_GUARD - 1);
  localparam logic [15:0] POST_LAST = 16'(POST_GUARD - 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t           state;
  logic             ack_m;
  logic             ack_s;
  logic [15:0]      len_q;
  logic [15:0]      guard;
  logic [CNT_W-1:0] cnt_q;
  logic [15:0]      len_new;
  logic             abort;

  assign len_new = (gate_len == 16'd0) ? 16'd1 : gate_len;
  assign busy    = (state != IDLE);
  assign abort   = !en &&
                   (state == PRE || state == GATE || state == POST);

  always_ff @(posedge clk_fx or negedge rst_n) begin
    if (!rst_n) begin
      ack_m <= 1'b0;
      ack_s <= 1'b0;
    end else begin
      ack_m <= hs.cnt_ack;
      ack_s <= ack_m;
    end
  end

  always_ff @(posedge clk_fx or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      gate       <= 1'b0;
      guard      <= '0;
      len_q      <= '0;
      cnt_q      <= '0;
      hs.fx_cnt  <= '0;
      hs.seq     <= '0;
      hs.cnt_req <= 1'b0;
    end else if (abort) begin
      // partial window is discarded without publishing
      state <= IDLE;
      gate  <= 1'b0;
      guard <= '0;
      cnt_q <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (en) begin
            state <= PRE;
            guard <= '0;
            len_q <= len_new;
          end
        end
        PRE: begin
          if (guard == PRE_LAST) begin
            state <= GATE;
            gate  <= 1'b1;
            guard <= '0;
          end else begin
            guard <= guard + 16'd1;
          end
        end
        GATE: begin
          if (cnt_q != CNT_MAX)
            cnt_q <= cnt_q + 1'b1;
          if (guard == len_q - 16'd1) begin
            state <= POST;
            gate  <= 1'b0;
            guard <= '0;
          end else begin
            guard <= guard + 16'd1;
          end
        end
        POST: begin
          if (guard == POST_LAST) begin
            state      <= HS_WAIT;
            guard      <= '0;
            hs.fx_cnt  <= cnt_q;
            hs.seq     <= hs.seq + 8'd1;
            hs.cnt_req <= 1'b1;
            cnt_q      <= '0;
          end else begin
            guard <= guard + 16'd1;
          end
        end
        HS_WAIT: begin
          if (ack_s) begin
            hs.cnt_req <= 1'b0;
            state      <= HS_REL;
          end
        end
        HS_REL: begin
          if (!ack_s) begin
            if (en) begin
              state <= PRE;
              guard <= '0;
              len_q <= len_new;
            end else begin
              state <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fx_gate_gen.sv
// Directed bench for fx_gate_gen: scoreboard of published
// counts, looped-back acknowledge, guard and abort checks.
module tb_fx_gate_gen;

  localparam int PRE  = 10;
  localparam int POST = 10;

  typedef struct {
    logic [31:0] cnt;
    logic [7:0]  seq;
  } exp_t;

  logic        clk_fx;
  logic        rst_n;
  logic        en;
  logic [15:0] gate_len;
  logic        gate;
  logic        busy;

  fx_gate_gen_if #(.CNT_W(32)) bus ();

  fx_gate_gen #(
    .CNT_W(32),
    .PRE_GUARD(PRE),
    .POST_GUARD(POST)
  ) dut (
    .clk_fx(clk_fx),
    .rst_n(rst_n),
    .en(en),
    .gate_len(gate_len),
    .gate(gate),
    .busy(busy),
    .hs(bus)
  );

  int   total;
  int   bad;
  exp_t q[$];
  exp_t held;
  logic [7:0] exp_seq;
  logic ack_en;
  int   ack_dly;
  int   hi_run;
  int   last_w;
  int   post_run;
  logic in_post;
  logic gate_p;
  logic req_p;

  initial begin
    clk_fx = 1'b0;
    forever #5 clk_fx = ~clk_fx;
  end

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic push_exp(input int len);
    exp_t e;
    exp_seq = exp_seq + 8'd1;
    e.cnt = 32'(len);
    e.seq = exp_seq;
    q.push_back(e);
  endtask

  task automatic wait_empty(input int max, input string tag);
    for (int i = 0; i < max; i++) begin
      @(posedge clk_fx);
      #1;
      if (q.size() == 0) break;
    end
    chk(tag, q.size(), 0);
  endtask

  task automatic wait_idle(input int max, input string tag);
    for (int i = 0; i < max; i++) begin
      @(negedge clk_fx);
      if (!busy) break;
    end
    chk(tag, busy, 0);
  endtask

  task automatic gate_rise(input int max, output int lows);
    lows = 0;
    for (int i = 0; i < max; i++) begin
      @(negedge clk_fx);
      if (gate) break;
      lows++;
    end
  endtask

  // acknowledge follows cnt_req after 3 cycles when enabled
  initial begin
    bus.cnt_ack = 1'b0;
    ack_dly = 0;
    forever begin
      @(negedge clk_fx);
      if (!ack_en) begin
        bus.cnt_ack = 1'b0;
        ack_dly = 0;
      end else if (bus.cnt_req != bus.cnt_ack) begin
        ack_dly++;
        if (ack_dly >= 3) begin
          bus.cnt_ack = bus.cnt_req;
          ack_dly = 0;
        end
      end else begin
        ack_dly = 0;
      end
    end
  end

  always @(negedge clk_fx) begin
    if (!rst_n) begin
      hi_run = 0;
      in_post = 1'b0;
      post_run = 0;
      gate_p = 1'b0;
      req_p = 1'b0;
    end else begin
      if (gate) begin
        hi_run++;
      end else if (gate_p) begin
        if (busy) begin
          last_w = hi_run;
          in_post = 1'b1;
          post_run = 1;
        end
        hi_run = 0;
      end else if (in_post && !bus.cnt_req) begin
        post_run++;
      end
      if (bus.cnt_req && !req_p) begin
        chk("post_guard", post_run, POST);
        in_post = 1'b0;
        if (q.size() == 0) begin
          chk("req_without_window", q.size(), 1);
        end else begin
          held = q.pop_front();
          chk("fx_cnt", bus.fx_cnt, held.cnt);
          chk("seq", bus.seq, held.seq);
          chk("gate_width", last_w, held.cnt);
        end
      end else if (bus.cnt_req) begin
        chk("hold_cnt", bus.fx_cnt, held.cnt);
        chk("hold_seq", bus.seq, held.seq);
        chk("hold_gate", gate, 0);
      end
      if (!busy) begin
        in_post = 1'b0;
        hi_run = 0;
      end
      gate_p = gate;
      req_p = bus.cnt_req;
    end
  end

  initial begin
    int lows;
    int highs;
    total = 0;
    bad = 0;
    exp_seq = 8'd0;
    ack_en = 1'b1;
    last_w = 0;
    rst_n = 1'b0;
    en = 1'b0;
    gate_len = 16'd0;
    repeat (3) @(negedge clk_fx);
    chk("rst_gate", gate, 0);
    chk("rst_fx_cnt", bus.fx_cnt, 0);
    chk("rst_seq", bus.seq, 0);
    chk("rst_req", bus.cnt_req, 0);
    chk("rst_busy", busy, 0);

    // long window with looped-back acknowledge
    rst_n = 1'b1;
    @(negedge clk_fx);
    gate_len = 16'd5000;
    en = 1'b1;
    push_exp(5000);
    gate_rise(50, lows);
    chk("pre_guard_5000", lows, PRE);
    wait_empty(6000, "req_timeout_5000");
    en = 1'b0;
    wait_idle(50, "idle_timeout_5000");

    // zero length becomes one; later gate_len change ignored
    @(negedge clk_fx);
    gate_len = 16'd0;
    en = 1'b1;
    push_exp(1);
    @(negedge clk_fx);
    gate_len = 16'd7;
    wait_empty(200, "req_timeout_len0");
    en = 1'b0;
    wait_idle(50, "idle_timeout_len0");

    // abort at gate cycle 100
    @(negedge clk_fx);
    gate_len = 16'd5000;
    en = 1'b1;
    gate_rise(50, lows);
    chk("pre_guard_abort", lows, PRE);
    repeat (99) @(negedge clk_fx);
    chk("abort_gate_hi", gate, 1);
    en = 1'b0;
    @(negedge clk_fx);
    chk("abort_gate_lo", gate, 0);
    chk("abort_busy", busy, 0);
    repeat (40) @(negedge clk_fx);
    chk("abort_no_req", bus.cnt_req, 0);
    chk("abort_seq", bus.seq, exp_seq);

    // acknowledge withheld for 1000 cycles
    ack_en = 1'b0;
    gate_len = 16'd20;
    en = 1'b1;
    push_exp(20);
    wait_empty(200, "req_timeout_hold");
    highs = 0;
    repeat (1000) begin
      @(negedge clk_fx);
      if (gate) highs++;
    end
    chk("hold_no_gate", highs, 0);
    chk("hold_req", bus.cnt_req, 1);
    chk("hold_busy", busy, 1);
    push_exp(20);
    ack_en = 1'b1;
    wait_empty(300, "req_timeout_after_hold");
    en = 1'b0;
    wait_idle(50, "idle_timeout_hold");

    // 256 back-to-back windows, seq wraps
    @(negedge clk_fx);
    gate_len = 16'd3;
    for (int i = 0; i < 256; i++) push_exp(3);
    en = 1'b1;
    wait_empty(20000, "req_timeout_wrap");
    en = 1'b0;
    wait_idle(50, "idle_timeout_wrap");
    chk("wrap_seq", bus.seq, exp_seq);

    // reset pulse while cnt_req is high
    @(negedge clk_fx);
    ack_en = 1'b0;
    gate_len = 16'd8;
    en = 1'b1;
    push_exp(8);
    wait_empty(200, "req_timeout_rst");
    @(negedge clk_fx);
    chk("pre_rst_req", bus.cnt_req, 1);
    rst_n = 1'b0;
    #1;
    chk("rst_mid_req", bus.cnt_req, 0);
    chk("rst_mid_cnt", bus.fx_cnt, 0);
    chk("rst_mid_seq", bus.seq, 0);
    chk("rst_mid_gate", gate, 0);
    exp_seq = 8'd0;
    ack_en = 1'b1;
    @(negedge clk_fx);
    @(negedge clk_fx);
    rst_n = 1'b1;
    push_exp(8);
    gate_rise(50, lows);
    chk("pre_guard_after_rst", lows, PRE);
    wait_empty(200, "req_timeout_after_rst");
    en = 1'b0;
    wait_idle(50, "idle_timeout_after_rst");

    repeat (5) @(negedge clk_fx);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
